uart_rx_recv: RTL and testbench

UART_RX_RECV -- requirements
Module: uart_rx_recv

---
 rtl/uart_rx_recv.sv | 116 +++++++++++
 tb/tb_uart_rx_recv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_recv.sv
// rtl/uart_rx_recv.sv - UART receiver: 16x oversampled, mid-bit sampling, frame error detection
module uart_rx_recv #(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int FRAME_WIDTH  = 8
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   uart_rx_din,
    output logic [0:FRAME_WIDTH-1] uart_rx_dout,
    output logic                   uart_rx_valid,
    output logic                   uart_rx_frame_err,
    output logic                   uart_rx_busy
);

    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W   = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [0:FRAME_WIDTH-1] shift_q, shift_d, dout_q, dout_d;
    logic                   valid_q, valid_d, ferr_q, ferr_d;
    logic                   tick, start_det, mid_start, sample_pt;

    assign tick      = (div_q == DIV_LAST);
    assign start_det = (state_q == IDLE) && !rx_s_q && rx_prev_q;
    assign mid_start = (state_q == START) && tick && (tick_cnt_q == 4'd7);
    assign sample_pt = tick && (tick_cnt_q == 4'd15);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_det) state_d = START;
            START: if (mid_start) state_d = rx_s_q ? IDLE : DATA;
            DATA:  if (sample_pt && bit_idx_q == LAST_IDX) state_d = STOP;
            STOP:  if (sample_pt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d      = (state_q == STOP) && sample_pt && rx_s_q;
        ferr_d       = (state_q == STOP) && sample_pt && !rx_s_q;
        dout_d       = valid_d ? shift_q : dout_q;
        uart_rx_busy = (state_q != IDLE);
    end

    // Divider and tick counter restart on the start edge so later samples land mid-bit.
    always_comb begin
        rx_meta_d  = uart_rx_din;
        rx_s_d     = rx_meta_q;
        rx_prev_d  = rx_s_q;
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        if (state_q != IDLE && tick) tick_cnt_d = tick_cnt_q + 4'd1;
        if (mid_start) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
        end
        if (state_q == DATA && sample_pt) begin
            shift_d[bit_idx_q] = rx_s_q;
            bit_idx_d          = bit_idx_q + IDX_W'(1);
        end
        if (start_det) begin
            div_d      = '0;
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_prev_q  <= rx_prev_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign uart_rx_dout      = dout_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_recv.sv
// tb/tb_uart_rx_recv.sv - scoreboard bench for uart_rx_recv with a line-level transmitter model
`timescale 1ns/1ps
module tb_uart_rx_recv;

    localparam int CLK_NS = 10;
    localparam int BIT_NS = 16 * CLK_NS;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       din;
    logic [0:7] dout;
    logic       valid, ferr, busy;

    uart_rx_recv #(
        .SYS_CLK_FREQ(16_000_000),
        .BAUD_RATE   (1_000_000),
        .FRAME_WIDTH (8)
    ) dut (
        .sys_clk          (sys_clk),
        .reset            (reset),
        .uart_rx_din      (din),
        .uart_rx_dout     (dout),
        .uart_rx_valid    (valid),
        .uart_rx_frame_err(ferr),
        .uart_rx_busy     (busy)
    );

    always #(CLK_NS/2) sys_clk = ~sys_clk;

    typedef struct packed {
        logic       err;
        logic [0:7] data;
    } exp_t;

    exp_t       sb[$];
    logic [0:7] model_dout;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         busy_total = 0;
    logic [0:7] last_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each frame occupies start + 8 data + stop bit periods; bit i of w is sent i-th.
    task automatic send_frame(input logic [0:7] w, input bit stop, input int bit_ns, input bit hold_low);
        exp_t e;
        e.err  = !stop;
        e.data = stop ? w : model_dout;
        if (stop) model_dout = w;
        sb.push_back(e);
        din = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            din = w[i];
            #(bit_ns);
        end
        din = stop;
        #(bit_ns);
        din = hold_low ? 1'b0 : 1'b1;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (!reset) begin
            if (valid && ferr) chk("valid_and_ferr_together", 1, 0);
            if (valid || ferr) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {valid, ferr}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind_ferr", ferr, e.err);
                    chk("pulse_dout", dout, e.data);
                end
            end else if (dout !== last_dout) begin
                chk("dout_hold", dout, last_dout);
            end
        end
        last_dout  = dout;
        busy_total = busy_total + (busy ? 1 : 0);
    end

    initial begin
        int b0, d, gap, spd;
        logic [0:7] w;
        bit stop;
        reset = 1'b1;
        din   = 1'b1;
        model_dout = '0;
        #23;
        chk("rst_dout", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_busy", busy, 0);
        #10 reset = 1'b0;
        #(BIT_NS);

        b0 = busy_total;
        w  = 8'b10110010;
        send_frame(w, 1'b1, BIT_NS, 1'b0);
        #(2 * BIT_NS);
        d = busy_total - b0;
        chk("busy_len_ok", (d >= 148 && d <= 156), 1);
        chk("dout_first", dout, 8'b10110010);

        b0 = busy_total;
        din = 1'b0;
        #(4 * CLK_NS);
        din = 1'b1;
        #(14 * CLK_NS);
        chk("glitch_busy_low", busy, 0);
        d = busy_total - b0;
        chk("glitch_busy_seen", (d > 0 && d <= 10), 1);
        #(BIT_NS);

        send_frame(8'h5A, 1'b0, BIT_NS, 1'b1);
        #(5 * BIT_NS);
        chk("break_idle", busy, 0);
        din = 1'b1;
        #(BIT_NS);
        send_frame(8'h3C, 1'b1, BIT_NS, 1'b0);
        #(BIT_NS);

        send_frame(8'hFF, 1'b1, BIT_NS, 1'b0);
        send_frame(8'h00, 1'b1, BIT_NS, 1'b0);
        #(2 * BIT_NS);

        din = 1'b0;
        #(BIT_NS);
        w = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            din = w[i];
            #(BIT_NS);
        end
        din = w[4];
        #(BIT_NS / 2);
        reset = 1'b1;
        #1;
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_ferr", ferr, 0);
        chk("midrst_busy", busy, 0);
        model_dout = '0;
        #(3 * CLK_NS);
        din = 1'b1;
        #(2 * CLK_NS);
        reset = 1'b0;
        #(BIT_NS);
        send_frame(8'h81, 1'b1, BIT_NS, 1'b0);
        #(BIT_NS);

        send_frame(8'hC3, 1'b1, BIT_NS + 5, 1'b0);
        #(BIT_NS);
        send_frame(8'hC3, 1'b1, BIT_NS - 5, 1'b0);
        #(BIT_NS);

        for (int n = 0; n < 24; n++) begin
            w    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            spd  = BIT_NS + 5 * ($urandom_range(0, 2) - 1);
            send_frame(w, stop, spd, 1'b0);
            gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            #(gap * BIT_NS);
        end

        for (int k = 0; k < 4000 && sb.size() != 0; k++) @(posedge sys_clk);
        #(3 * BIT_NS);
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_dout", dout, model_dout);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
